slave_mem_sync: RTL and testbench

- Synchronous, parametrised two-port (1W/1R) word memory for the slave side of the SDRAM/unidirectional-bus system.
- Replaces asynchronous read/write with clocked access: byte-lane write strobes, fixed configurable read latency, a read-valid qualifier, and defined same-address read/write collision behaviour, so the controller no longer has to prevent collisions.

---
 rtl/slave_mem_pkg.sv | 28 ++
 rtl/slave_mem_sync_if.sv | 27 ++
 rtl/slave_mem_rd_pipe.sv | 56 +++++
 rtl/slave_mem_sync.sv | 73 +++++++
 tb/tb_slave_mem_sync.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/slave_mem_pkg.sv
// Shared constants and the byte-lane merge helper for the synchronous slave memory.
// Used by both the array write path and write-first collision forwarding.
package slave_mem_pkg;

    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    localparam int RDLATENCY_MIN = 1;
    localparam int RDLATENCY_MAX = 4;

    // Widest word the merge helper handles; callers cast in and out of this width.
    localparam int BM_MAX_W = 1024;
    localparam int BM_MAX_B = BM_MAX_W / 8;

    function automatic logic [BM_MAX_W-1:0] ByteMerge(
        input logic [BM_MAX_W-1:0] old_word,
        input logic [BM_MAX_W-1:0] new_word,
        input logic [BM_MAX_B-1:0] strb
    );
        logic [BM_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BM_MAX_B; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/slave_mem_sync_if.sv
// Write/read request and read-response signals of the synchronous slave memory.
// The master drives requests; the slave returns registered read data.
interface slave_mem_sync_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8,
    parameter int NUMBYTES  = DATAWIDTH / 8
);
    logic                 Wen;
    logic [ADDRWIDTH-1:0] WrAddrIn;
    logic [DATAWIDTH-1:0] DataIn;
    logic [NUMBYTES-1:0]  WrStrb;
    logic                 Ren;
    logic [ADDRWIDTH-1:0] RdAddrIn;
    logic [DATAWIDTH-1:0] DataOut;
    logic                 DataValid;
    logic                 Collision;

    modport master (
        output Wen, WrAddrIn, DataIn, WrStrb, Ren, RdAddrIn,
        input  DataOut, DataValid, Collision
    );

    modport slave (
        input  Wen, WrAddrIn, DataIn, WrStrb, Ren, RdAddrIn,
        output DataOut, DataValid, Collision
    );
endinterface

// File: rtl/slave_mem_rd_pipe.sv
// Read-response shift register: data, valid and collision flag advance together.
// Only valid/collision and the output data word are reset; inner data stages hold.
module slave_mem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              vld_in,
    input  logic              coll_in,
    output logic [DATA_W-1:0] data_out,
    output logic              vld_out,
    output logic              coll_out
);

    logic [DATA_W-1:0] data_p   [STAGES];
    logic [DATA_W-1:0] data_src [STAGES];
    logic [STAGES-1:0] vld_p, coll_p;
    logic [STAGES-1:0] vld_src, coll_src;

    for (genvar s = 0; s < STAGES; s++) begin : g_src
        if (s == 0) begin : g_head
            assign data_src[s] = data_in;
            assign vld_src[s]  = vld_in;
            assign coll_src[s] = vld_in & coll_in;
        end else begin : g_tail
            assign data_src[s] = data_p[s-1];
            assign vld_src[s]  = vld_p[s-1];
            assign coll_src[s] = coll_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            coll_p <= '0;
        end else begin
            vld_p  <= vld_src;
            coll_p <= coll_src;
        end
    end

    // Each stage only captures on a valid word, so the output holds between results.
    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (rst && (s == STAGES - 1)) data_p[s] <= '0;
            else if (vld_src[s])          data_p[s] <= data_src[s];
        end
    end

    assign data_out = data_p[STAGES-1];
    assign vld_out  = vld_p[STAGES-1];
    assign coll_out = coll_p[STAGES-1];

endmodule

// File: rtl/slave_mem_sync.sv
// Synchronous 1W/1R word memory with byte strobes, fixed read latency and
// defined same-address collision behaviour (read-first or write-first).
module slave_mem_sync
    import slave_mem_pkg::*;
#(
    parameter int DATAWIDTH     = 32,
    parameter int ADDRWIDTH     = 8,
    parameter int RDLATENCY     = 2,
    parameter int COLLISIONMODE = 0,
    parameter int NUMBYTES      = DATAWIDTH / 8
) (
    input logic             Clk,
    input logic             Rst,
    slave_mem_sync_if.slave bus
);

    localparam int DEPTH = 2 ** ADDRWIDTH;

    if (RDLATENCY < RDLATENCY_MIN || RDLATENCY > RDLATENCY_MAX) begin : g_bad_latency
        $error("slave_mem_sync: RDLATENCY out of range");
    end
    if (NUMBYTES * 8 != DATAWIDTH || DATAWIDTH > BM_MAX_W) begin : g_bad_width
        $error("slave_mem_sync: DATAWIDTH must be a multiple of 8 within merge range");
    end
    if (COLLISIONMODE != COLL_READ_FIRST && COLLISIONMODE != COLL_WRITE_FIRST) begin : g_bad_mode
        $error("slave_mem_sync: COLLISIONMODE must be 0 or 1");
    end

    function automatic logic [DATAWIDTH-1:0] merge_word(
        input logic [DATAWIDTH-1:0] old_word,
        input logic [DATAWIDTH-1:0] new_word,
        input logic [NUMBYTES-1:0]  strb
    );
        return DATAWIDTH'(ByteMerge(BM_MAX_W'(old_word), BM_MAX_W'(new_word), BM_MAX_B'(strb)));
    endfunction

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic [DATAWIDTH-1:0] wr_word_p0;
    logic [DATAWIDTH-1:0] rd_word_p0;
    logic [DATAWIDTH-1:0] rd_data_p0;
    logic                 coll_p0;
    logic                 vld_p0;

    // Request stage: the array still holds pre-write contents at the sampling edge.
    always_comb begin
        wr_word_p0 = merge_word(mem[bus.WrAddrIn], bus.DataIn, bus.WrStrb);
        rd_word_p0 = mem[bus.RdAddrIn];
        coll_p0    = bus.Wen && bus.Ren && (bus.WrAddrIn == bus.RdAddrIn);
        vld_p0     = bus.Ren;
        rd_data_p0 = rd_word_p0;
        if (COLLISIONMODE == COLL_WRITE_FIRST && coll_p0) rd_data_p0 = wr_word_p0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst && bus.Wen) mem[bus.WrAddrIn] <= wr_word_p0;
    end

    slave_mem_rd_pipe #(
        .DATA_W (DATAWIDTH),
        .STAGES (RDLATENCY)
    ) u_rd_pipe (
        .clk      (Clk),
        .rst      (Rst),
        .data_in  (rd_data_p0),
        .vld_in   (vld_p0),
        .coll_in  (coll_p0),
        .data_out (bus.DataOut),
        .vld_out  (bus.DataValid),
        .coll_out (bus.Collision)
    );

endmodule

// File: tb/tb_slave_mem_sync.sv
// Drives four memory variants (latency 2 read-first, latency 2 write-first,
// latency 1, latency 4) with identical stimulus and scoreboards each response.
module tb_slave_mem_sync;
    import slave_mem_pkg::*;

    localparam int NDUT = 4;

    function automatic int lat_of(input int g);
        case (g)
            2:       return 1;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int mode_of(input int g);
        return (g == 1) ? COLL_WRITE_FIRST : COLL_READ_FIRST;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        wen, ren;
    logic [7:0]  waddr, raddr;
    logic [31:0] din;
    logic [3:0]  strb;

    logic [31:0] dout [NDUT];
    logic        dv   [NDUT];
    logic        col  [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        slave_mem_sync_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) bus ();
        assign bus.Wen      = wen;
        assign bus.WrAddrIn = waddr;
        assign bus.DataIn   = din;
        assign bus.WrStrb   = strb;
        assign bus.Ren      = ren;
        assign bus.RdAddrIn = raddr;

        slave_mem_sync #(
            .DATAWIDTH     (32),
            .ADDRWIDTH     (8),
            .RDLATENCY     (lat_of(g)),
            .COLLISIONMODE (mode_of(g))
        ) dut (
            .Clk (clk),
            .Rst (rst),
            .bus (bus)
        );

        assign dout[g] = bus.DataOut;
        assign dv[g]   = bus.DataValid;
        assign col[g]  = bus.Collision;
    end

    typedef struct {
        logic [31:0] d;
        logic        c;
        int          due;
    } exp_t;

    exp_t        sb [NDUT][$];
    logic [31:0] mdl [256];
    logic [31:0] last [NDUT];
    int          cyc    = 0;
    int          total  = 0;
    int          passed = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = o;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = n[8*b +: 8];
        return m;
    endfunction

    task automatic check(input string tag, input int dut, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d cyc%0d: got %h expected %h", tag, dut, cyc, obs, exp);
    endtask

    // One clock: model the edge, then compare every variant at the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < NDUT; i++) begin
                sb[i].delete();
                last[i] = '0;
            end
        end else begin
            if (ren) begin
                for (int i = 0; i < NDUT; i++) begin
                    exp_t e;
                    e.d = mdl[raddr];
                    e.c = wen && (waddr == raddr);
                    if (e.c && mode_of(i) == COLL_WRITE_FIRST) e.d = merge(e.d, din, strb);
                    e.due = cyc + lat_of(i) - 1;
                    sb[i].push_back(e);
                end
            end
            if (wen) mdl[waddr] = merge(mdl[waddr], din, strb);
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            logic exp_v;
            while (sb[i].size() > 0 && sb[i][0].due < cyc) void'(sb[i].pop_front());
            exp_v = (sb[i].size() > 0) && (sb[i][0].due == cyc);
            check("DataValid", i, 32'(dv[i]), 32'(exp_v));
            if (exp_v) begin
                exp_t e;
                e = sb[i].pop_front();
                check("DataOut", i, dout[i], e.d);
                check("Collision", i, 32'(col[i]), 32'(e.c));
                last[i] = e.d;
            end else begin
                check("DataOut_hold", i, dout[i], last[i]);
                check("Collision_idle", i, 32'(col[i]), 32'h0);
            end
        end
    endtask

    task automatic idle(input int n);
        wen = 1'b0;
        ren = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1'b1; waddr = a; din = d; strb = s;
        step();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        ren = 1'b1; raddr = a;
        step();
        ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; din = '0; strb = '0;
        step();
        step();
        rst = 1'b0;
        idle(1);

        // Full-word write then read.
        wr(8'h10, 32'hDEADBEEF, 4'hF);
        rd(8'h10);
        idle(5);

        // Byte strobes.
        wr(8'h05, 32'h11223344, 4'hF);
        wr(8'h05, 32'hAABBCCDD, 4'b0101);
        rd(8'h05);
        idle(5);

        // Same-address collision, then a plain read of the committed word.
        wr(8'h20, 32'h00000001, 4'hF);
        wen = 1'b1; waddr = 8'h20; din = 32'h000000FF; strb = 4'b0001;
        ren = 1'b1; raddr = 8'h20;
        step();
        wen = 1'b0; ren = 1'b0;
        rd(8'h20);
        idle(5);

        // Streaming reads after preload.
        for (int k = 0; k < 8; k++) wr(8'(k), 32'(k) * 32'h01010101, 4'hF);
        for (int k = 0; k < 8; k++) begin
            ren = 1'b1; raddr = 8'(k);
            step();
        end
        idle(6);

        // Reset while a read is in flight; contents must survive.
        ren = 1'b1; raddr = 8'h10;
        step();
        ren = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        idle(6);
        rd(8'h10);
        idle(5);

        // Mixed random traffic over the preloaded window.
        for (int k = 0; k < 40; k++) begin
            wen   = 1'($urandom_range(0, 1));
            ren   = 1'($urandom_range(0, 1));
            waddr = 8'($urandom_range(0, 7));
            raddr = 8'($urandom_range(0, 7));
            din   = $urandom;
            strb  = 4'($urandom_range(0, 15));
            step();
        end
        idle(6);

        for (int i = 0; i < NDUT; i++) check("sb_drained", i, 32'(sb[i].size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
